// File: rtl/alu_sched_pkg.sv
// rtl/alu_sched_pkg.sv - op encodings and result record shared by the ALU scheduler files
package alu_sched_pkg;

  localparam logic OP_ADD = 1'b1;
  localparam logic OP_MUL = 1'b0;

  localparam int RESP_TAG_W = 4;

  typedef struct packed {
    logic [31:0]           data;
    logic                  op;
    logic [RESP_TAG_W-1:0] tag;
  } alu_resp_t;

  function automatic int max_lat(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/alu_sched_if.sv
// rtl/alu_sched_if.sv - request/response handshake bundle between a controller and alu_sched
interface alu_sched_if #(
  parameter int TAG_W = 4
);

  logic             req_val;
  logic             req_rdy;
  logic             req_op;
  logic [31:0]      req_in0;
  logic [31:0]      req_in1;
  logic [TAG_W-1:0] req_tag;

  logic             resp_val;
  logic             resp_rdy;
  logic [31:0]      resp_data;
  logic             resp_op;
  logic [TAG_W-1:0] resp_tag;

  modport master (
    output req_val, req_op, req_in0, req_in1, req_tag, resp_rdy,
    input  req_rdy, resp_val, resp_data, resp_op, resp_tag
  );

  modport slave (
    input  req_val, req_op, req_in0, req_in1, req_tag, resp_rdy,
    output req_rdy, resp_val, resp_data, resp_op, resp_tag
  );

endinterface

// File: rtl/alu_sched_fifo.sv
// rtl/alu_sched_fifo.sv - registered-output response FIFO, power-of-two depth, no fall-through
module alu_sched_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] pop_data,
  output logic         full,
  output logic         empty,
  output logic [AW:0]  count
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_pop;

  assign do_pop   = pop & !empty;
  assign empty    = (count == '0);
  assign full     = (count == (AW+1)'(DEPTH));
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + AW'(1);
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      case ({push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/alu_sched.sv
// rtl/alu_sched.sv - issue scheduler and completion tracker for the shared add/mult ALU
// Optional ALU_SCHED_STATS_EN adds issue and stall counters as output ports.
module alu_sched
  import alu_sched_pkg::*;
#(
  parameter int ADD_LAT    = 4,
  parameter int MUL_LAT    = 4,
  parameter int TAG_W      = 4,
  parameter int RESP_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  alu_sched_if.slave  bus,
  output logic [31:0] alu_in0,
  output logic [31:0] alu_in1,
  output logic        alu_opsel,
  input  logic [31:0] alu_out
`ifdef ALU_SCHED_STATS_EN
  ,
  output logic [31:0] stat_add_issued,
  output logic [31:0] stat_mul_issued,
  output logic [31:0] stat_stall_cycles
`endif
);

  localparam int MAXLAT = max_lat(ADD_LAT, MUL_LAT);
  localparam int CW     = $clog2(RESP_DEPTH) + 1;
  localparam int PW     = 33 + TAG_W;
  localparam logic [CW:0] DEPTH_C = RESP_DEPTH[CW:0];

  logic [MAXLAT-1:0] busy;
  logic [MAXLAT-1:0] op_tab;
  logic [TAG_W-1:0]  tag_tab [MAXLAT];
  logic [MAXLAT:0]   busy_ext;
  logic [CW-1:0]     inflight;
  logic [CW-1:0]     fifo_count;
  logic              fifo_full;
  logic              fifo_empty;
  logic [PW-1:0]     fifo_head;
  logic              slot_free;
  logic              credit_ok;
  logic              fire;
  logic              done;

  assign alu_in0 = bus.req_in0;
  assign alu_in1 = bus.req_in1;

  // Top bit is a permanently empty slot so a max-latency op always finds room.
  assign busy_ext  = {1'b0, busy};
  assign slot_free = (bus.req_op == OP_ADD) ? !busy_ext[ADD_LAT] : !busy_ext[MUL_LAT];
  assign credit_ok = ({1'b0, inflight} + {1'b0, fifo_count}) < DEPTH_C;
  assign bus.req_rdy = !reset & slot_free & credit_ok;
  assign fire      = bus.req_val & bus.req_rdy;
  assign done      = busy[0];
  assign alu_opsel = busy[0] ? op_tab[0] : 1'b0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy   <= '0;
      op_tab <= '0;
      for (int k = 0; k < MAXLAT; k++) tag_tab[k] <= '0;
    end else begin
      busy   <= busy >> 1;
      op_tab <= op_tab >> 1;
      for (int k = 0; k < MAXLAT - 1; k++) tag_tab[k] <= tag_tab[k+1];
      tag_tab[MAXLAT-1] <= '0;
      if (fire) begin
        if (bus.req_op == OP_ADD) begin
          busy[ADD_LAT-1]    <= 1'b1;
          op_tab[ADD_LAT-1]  <= OP_ADD;
          tag_tab[ADD_LAT-1] <= bus.req_tag;
        end else begin
          busy[MUL_LAT-1]    <= 1'b1;
          op_tab[MUL_LAT-1]  <= OP_MUL;
          tag_tab[MUL_LAT-1] <= bus.req_tag;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      inflight <= '0;
    end else begin
      case ({fire, done})
        2'b10:   inflight <= inflight + CW'(1);
        2'b01:   inflight <= inflight - CW'(1);
        default: inflight <= inflight;
      endcase
    end
  end

  alu_sched_fifo #(
    .DEPTH (RESP_DEPTH),
    .W     (PW)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (done & !fifo_full),
    .push_data ({alu_out, op_tab[0], tag_tab[0]}),
    .pop       (bus.resp_val & bus.resp_rdy),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign bus.resp_val = !fifo_empty;
  assign {bus.resp_data, bus.resp_op, bus.resp_tag} = fifo_head;

`ifdef ALU_SCHED_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_add_issued   <= '0;
      stat_mul_issued   <= '0;
      stat_stall_cycles <= '0;
    end else begin
      if (fire && bus.req_op == OP_ADD) stat_add_issued <= stat_add_issued + 32'd1;
      if (fire && bus.req_op == OP_MUL) stat_mul_issued <= stat_mul_issued + 32'd1;
      if (bus.req_val && !bus.req_rdy)  stat_stall_cycles <= stat_stall_cycles + 32'd1;
    end
  end
`endif

endmodule
